// File: rtl/mmm_div_pkg.sv
// Shared definitions for the 90-bit restoring divider: default widths,
// controller state encoding and the value reported on quotient overflow.
package mmm_div_pkg;

    localparam int IDW_DEF = 90;          // divisor / quotient / remainder width
    localparam int DDW_DEF = 2 * IDW_DEF; // dividend width
    localparam int CW_DEF  = 7;           // iteration counter width, 2^CW > IDW

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // On overflow or divide-by-zero every quotient bit is forced to this value.
    localparam logic QUO_OVF_FILL = 1'b1;

endpackage

// File: rtl/mmm_div_step.sv
// One radix-2 restoring step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep the difference if it fits.
module mmm_div_step
    import mmm_div_pkg::*;
#(
    parameter int IDW = IDW_DEF
) (
    input  logic [IDW-1:0] pr,       // partial remainder, always < divisor
    input  logic           sr_msb,   // next dividend bit from the shift register
    input  logic [IDW-1:0] divisor,
    output logic [IDW-1:0] pr_next,
    output logic           q_bit
);

    // The shifted remainder needs IDW+1 bits so the compare cannot overflow.
    // When the subtraction is taken the true difference is below the divisor,
    // so computing it modulo 2^IDW on the low bits is exact.
    logic [IDW:0] pr_sh;

    // Trial subtract and select.
    always_comb begin
        pr_sh   = {pr, sr_msb};
        pr_next = pr_sh[IDW-1:0];
        q_bit   = 1'b0;
        if (pr_sh >= {1'b0, divisor}) begin
            pr_next = pr_sh[IDW-1:0] - divisor;
            q_bit   = 1'b1;
        end
    end

endmodule

// File: rtl/mmm_div_90b.sv
// Sequential radix-2 restoring divider: DDW-bit dividend by IDW-bit divisor,
// one quotient bit per cycle, one operation in flight.
//
// Handshake: an input transfer happens on a rising edge where i_valid and
// o_ready are both high; a result transfer happens on a rising edge where
// o_valid and i_ready are both high. o_ready is high only when idle, o_valid
// only while a result is held, and the result data stays stable until taken.
module mmm_div_90b
    import mmm_div_pkg::*;
#(
    parameter int IDW = IDW_DEF,
    parameter int DDW = DDW_DEF,
    parameter int CW  = CW_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [DDW-1:0] i_dividend,
    input  logic [IDW-1:0] i_divisor,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [IDW-1:0] o_quo,
    output logic [IDW-1:0] o_rem,
    output logic           o_ovf,
    output logic [1:0]     o_state    // controller state, for observation only
);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [IDW-1:0] pr_q;     // partial remainder
    logic [IDW-1:0] sr_q;     // dividend low bits out, quotient bits in
    logic [IDW-1:0] dvs_q;
    logic [IDW-1:0] quo_q;
    logic [IDW-1:0] rem_q;
    logic           ovf_q;

    logic           acc_ovf;
    logic [IDW-1:0] step_pr;
    logic           step_q;

    // The quotient only fits in IDW bits when the dividend high half is below
    // the divisor; a zero divisor always fails this test.
    assign acc_ovf = (i_dividend[DDW-1:IDW] >= i_divisor);

    mmm_div_step #(
        .IDW (IDW)
    ) u_step (
        .pr      (pr_q),
        .sr_msb  (sr_q[IDW-1]),
        .divisor (dvs_q),
        .pr_next (step_pr),
        .q_bit   (step_q)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_valid)       state_d = acc_ovf ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == '0)   state_d = ST_DONE;
            ST_DONE: if (i_ready)       state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            pr_q  <= '0;
            sr_q  <= '0;
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        dvs_q <= i_divisor;
                        pr_q  <= i_dividend[DDW-1:IDW];
                        sr_q  <= i_dividend[IDW-1:0];
                        if (acc_ovf) begin
                            // No iterations: report saturated quotient and
                            // pass the dividend low half through as remainder.
                            quo_q <= {IDW{QUO_OVF_FILL}};
                            rem_q <= i_dividend[IDW-1:0];
                            ovf_q <= 1'b1;
                            cnt_q <= '0;
                        end else begin
                            ovf_q <= 1'b0;
                            cnt_q <= CW'(IDW - 1);
                        end
                    end
                end
                ST_CALC: begin
                    pr_q <= step_pr;
                    sr_q <= {sr_q[IDW-2:0], step_q};
                    if (cnt_q == '0) begin
                        // Last step: publish quotient and remainder together.
                        quo_q <= {sr_q[IDW-2:0], step_q};
                        rem_q <= step_pr;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_quo   = quo_q;
    assign o_rem   = rem_q;
    assign o_ovf   = ovf_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_mmm_div_90b.sv
// Directed and constructed-random tests for mmm_div_90b against an
// arithmetic reference model with a cycle-level expectation of the handshakes.
module tb_mmm_div_90b;

  localparam int IDW = 90;
  localparam int DDW = 180;
  localparam int EW  = 1 + 2 * IDW;   // {ovf, quo, rem}
  localparam logic [IDW-1:0] ONES = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           i_valid = 1'b0;
  logic           i_ready = 1'b1;
  logic [DDW-1:0] i_dividend = '0;
  logic [IDW-1:0] i_divisor = '0;
  logic           o_ready, o_valid, o_ovf;
  logic [IDW-1:0] o_quo, o_rem;
  logic [1:0]     o_state;

  mmm_div_90b dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_quo      (o_quo),
    .o_rem      (o_rem),
    .o_ovf      (o_ovf),
    .o_state    (o_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [DDW-1:0] act, input logic [DDW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic fail_to(input string name);
    n_checks++;
    $display("FAIL %s: got no response within bound, required a response", name);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] ref_div(input logic [DDW-1:0] dd, input logic [IDW-1:0] dv);
    logic [DDW-1:0] q, r;
    if (dv == '0) return {1'b1, ONES, dd[IDW-1:0]};
    q = dd / DDW'(dv);
    r = dd % DDW'(dv);
    if (q > DDW'(ONES)) return {1'b1, ONES, dd[IDW-1:0]};
    return {1'b0, q[IDW-1:0], r[IDW-1:0]};
  endfunction

  // Scoreboard: drivers push the arithmetic answer, the model pops on accept.
  logic [EW-1:0] exp_q[$];

  logic          m_busy  = 1'b0;
  logic          m_valid = 1'b0;
  int            m_wait  = 0;
  logic [EW-1:0] m_res   = '0;
  logic          m_ready;
  assign m_ready = !m_busy && !m_valid;

  // Timing model: IDW edges of work after accept, none on overflow; result
  // held until taken.
  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_wait  <= 0;
      m_res   <= '0;
    end else if (m_valid) begin
      if (i_ready) m_valid <= 1'b0;
    end else if (m_busy) begin
      if (m_wait == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
      end
      m_wait <= m_wait - 1;
    end else if (i_valid && exp_q.size() > 0) begin
      m_res <= exp_q[0];
      if (exp_q[0][EW-1]) begin
        m_valid <= 1'b1;
      end else begin
        m_busy <= 1'b1;
        m_wait <= IDW;
      end
      exp_q.delete(0);
    end
  end

  // Compare process: handshake outputs every cycle, data while a result is held.
  always @(negedge clk) begin
    if (chk_en) begin
      check("o_valid", o_valid, m_valid);
      check("o_ready", o_ready, m_ready);
      check("o_state", o_state, m_valid ? 2'd2 : (m_busy ? 2'd1 : 2'd0));
      if (m_valid) begin
        check("o_quo", o_quo, m_res[EW-2:IDW]);
        check("o_rem", o_rem, m_res[IDW-1:0]);
        check("o_ovf", o_ovf, m_res[EW-1]);
      end
    end
  end

  // ---------------- driver tasks (enter and leave at a negedge) ----------------
  task automatic send_op(input logic [DDW-1:0] dd, input logic [IDW-1:0] dv);
    int g = 0;
    while (!m_ready && g < 400) begin
      @(negedge clk);
      g++;
    end
    if (!m_ready) begin
      fail_to("send_wait");
      return;
    end
    i_dividend = dd;
    i_divisor  = dv;
    i_valid    = 1'b1;
    exp_q.push_back(ref_div(dd, dv));
    @(posedge clk);
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  // lat counts edges from the accept edge (inclusive) to o_valid visible.
  task automatic wait_valid(output logic [IDW-1:0] q, output logic [IDW-1:0] r,
                            output logic ov, output int lat);
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    q  = o_quo;
    r  = o_rem;
    ov = o_ovf;
    if (!o_valid) fail_to("o_valid_wait");
  endtask

  task automatic collect(input bit stall, output logic [IDW-1:0] q, output logic [IDW-1:0] r,
                         output logic ov, output int lat);
    bit done;
    wait_valid(q, r, ov, lat);
    done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      i_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      done    = i_ready;
      @(posedge clk);
      @(negedge clk);
    end
    i_ready = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [IDW-1:0] q, r, a, b, c;
    logic           ov;
    int             lat;
    logic [DDW-1:0] mx, dd;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", o_ready, 1'b1);
    check("rst_valid", o_valid, 1'b0);
    check("rst_quo", o_quo, '0);
    check("rst_rem", o_rem, '0);
    check("rst_ovf", o_ovf, 1'b0);
    check("rst_state", o_state, 2'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Basic: 100 / 7 = 14 r 2
    send_op(180'd100, 90'd7);
    collect(1'b0, q, r, ov, lat);
    check("basic_quo", q, 90'd14);
    check("basic_rem", r, 90'd2);
    check("basic_ovf", ov, 1'b0);
    check("basic_lat", lat, IDW + 1);

    // Extremes: (2^90-1)^2 + (2^90-2) over 2^90-1
    mx = DDW'(ONES);
    dd = mx * mx + (mx - 1);
    send_op(dd, ONES);
    collect(1'b0, q, r, ov, lat);
    check("ext_quo", q, ONES);
    check("ext_rem", r, ONES - 1);
    check("ext_ovf", ov, 1'b0);

    // Divide by zero: result on the edge after accept
    send_op(180'd5, '0);
    collect(1'b0, q, r, ov, lat);
    check("dz_ovf", ov, 1'b1);
    check("dz_quo", q, ONES);
    check("dz_rem", r, 90'd5);
    check("dz_lat", lat, 1);

    // Quotient overflow: high half equals divisor
    send_op(DDW'(7) << IDW, 90'd7);
    collect(1'b0, q, r, ov, lat);
    check("ovf_ovf", ov, 1'b1);
    check("ovf_quo", q, ONES);
    check("ovf_rem", r, 90'd0);

    // Largest non-overflowing high half, then back-to-back ops
    send_op({90'd6, ONES}, 90'd7);
    collect(1'b0, q, r, ov, lat);
    check("edge_ovf", ov, 1'b0);
    send_op(180'd1, 90'd1);
    collect(1'b0, q, r, ov, lat);
    check("one_quo", q, 90'd1);
    check("one_rem", r, 90'd0);

    // Backpressure: hold the result 20 cycles while junk i_valid arrives
    i_ready = 1'b0;
    send_op(180'd1234567, 90'd89);
    wait_valid(q, r, ov, lat);
    for (int k = 0; k < 20; k++) begin
      i_valid    = (k % 3 == 0);
      i_dividend = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      i_divisor  = 90'd3;
      @(posedge clk);
      @(negedge clk);
    end
    i_valid = 1'b0;
    check("bp_quo", o_quo, 90'd13871);
    check("bp_rem", o_rem, 90'd48);
    check("bp_ready", o_ready, 1'b0);
    i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_release_ready", o_ready, 1'b1);
    check("bp_release_valid", o_valid, 1'b0);

    // Reset in the middle of CALC discards the operation
    send_op(180'd1000000, 90'd3);
    repeat (39) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_ready", o_ready, 1'b1);
    check("mid_rst_quo", o_quo, '0);
    check("mid_rst_rem", o_rem, '0);
    check("mid_rst_ovf", o_ovf, 1'b0);
    repeat (100) @(negedge clk);
    send_op(180'd1000, 90'd10);
    collect(1'b0, q, r, ov, lat);
    check("post_rst_quo", q, 90'd100);
    check("post_rst_rem", r, 90'd0);

    // Constructed operands: dividend = a*b + c with c < b, random stalls
    for (int k = 0; k < 40; k++) begin
      a = IDW'({$urandom(), $urandom(), $urandom()});
      b = IDW'({$urandom(), $urandom(), $urandom()});
      if (k % 4 == 0) b = IDW'($urandom_range(1, 1000));
      if (b == '0) b = 90'd1;
      c = IDW'({$urandom(), $urandom(), $urandom()}) % b;
      dd = DDW'(a) * DDW'(b) + DDW'(c);
      send_op(dd, b);
      collect(1'b1, q, r, ov, lat);
      check("rnd_quo", q, a);
      check("rnd_rem", r, c);
      check("rnd_ovf", ov, 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
